uart_tx_packet_engine: RTL
==========================

// Module: uart_tx_packet_engine
// PURPOSE
//  Parametrised UART transmit engine: buffers bytes in an internal FIFO and sends a packet of
//  num_bytes frames on tx with configurable data width, parity, stop bits and inter-frame gap.
//  Sits under chip top beside the baud clock divider, which supplies clock_enable (one pulse per bit period).
//  Keeps cumulative byte and line statistics for the debug/status path.
// PARAMETERS
//  DATA_BITS   8   frame data width, 5..9
//  FIFO_DEPTH  16  input FIFO entries, power of 2, >=2
//  NUM_W       15  width of num_bytes
//  CNT_W       17  width of data_counter
//  GAP_W       2   width of delay (inter-frame gap, bit periods)
//  PARITY_EN   0   1 = append parity bit after data
//  PARITY_ODD  0   1 = odd parity, 0 = even
//  STOP_BITS   1   1 or 2
//  LF_CHAR     8'h0A  data value counted by line_counter (compared on low min(8,DATA_BITS) bits)
// PORTS
//  system_clock  in   1          single clock; all logic rising edge
//  rst_n         in   1          asynchronous, active-low reset
//  clock_enable  in   1          baud tick, one system_clock cycle wide
//  s_valid       in   1          FIFO write request
//  s_data        in   DATA_BITS  FIFO write data
//  s_ready       out  1          FIFO not full; write accepted when s_valid&&s_ready
//  start         in   1          packet start pulse; sampled only when busy=0
//  num_bytes     in   NUM_W      frames in packet, latched on accepted start
//  delay         in   GAP_W      idle bit periods between frames, latched on accepted start
//  tx            out  1          serial line, idle high, registered
//  busy          out  1          packet in progress
//  done          out  1          one-cycle pulse at packet end
//  data_counter  out  CNT_W      frames completed since reset, wraps modulo 2^CNT_W
//  line_counter  out  8          frames equal to LF_CHAR completed since reset, wraps
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): tx=1, busy=0, done=0, counters=0, FIFO flushed,
//   fifo_level=0, s_ready=1, state=IDLE. Release is synchronous to system_clock.
//  FIFO: s_ready = (level<FIFO_DEPTH), combinational from level only. Push and pop in same cycle:
//   both occur, level unchanged. Push when full: ignored, data dropped, no error.
//  start accepted iff start=1 && busy=0 on a clock edge; busy=1 from next cycle. start while busy ignored.
//  num_bytes==0: no frames; busy stays 0; done pulses the cycle after start.
//  FSM advances only on edges where clock_enable=1; tx is registered from state so each bit lasts
//   exactly one enable interval:
//   IDLE     -> LOAD on accepted start (num_bytes>0), independent of clock_enable.
//   LOAD     on enable: if FIFO non-empty pop word, tx=0, -> START; else tx=1, stay (wait, no timeout).
//   START    on enable -> DATA, tx=data[0].
//   DATA     LSB first; after DATA_BITS periods -> PARITY (PARITY_EN) else STOP, tx=parity/1.
//   PARITY   parity = ^data ^ PARITY_ODD; on enable -> STOP, tx=1.
//   STOP     STOP_BITS periods of tx=1; at end: data_counter++, line_counter++ if word==LF_CHAR,
//            remaining--. remaining>0: -> GAP if delay>0 else LOAD logic applied same edge
//            (back-to-back start bit). remaining==0: -> IDLE, busy=0 and done=1 on that edge.
//   GAP      delay periods of tx=1, then LOAD logic.
//  No gap after final frame. Frame length = 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods.
//  done high exactly one system_clock cycle per packet; busy falls on the same edge done rises.
//  clock_enable held high is legal (1 bit per system_clock).
// TESTING
//  1 Reset mid-frame (rst_n low 1 cycle during DATA) -> tx=1 asynchronously, busy=0, counters=0,
//    fifo_level=0; next packet transmits correctly.
//  2 Defaults, enable every 4 cycles, push 0x55, start num_bytes=1 delay=0 -> tx 0,1,0,1,0,1,0,1,0,1
//    each 4 cycles; done one pulse at end of stop; data_counter=1, line_counter=0.
//  3 Push 0x0A,0x41,0x0A, start num_bytes=3 delay=2 -> 2 idle periods between frames, none after
//    last; total 34 bit periods busy; data_counter=3, line_counter=2.
//  4 start num_bytes=2 with FIFO holding 1 word -> first frame sent, tx idles high in LOAD until push
//    20 cycles later, then second frame; done once after it.
//  5 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07 -> parity bit 1, two stop periods (12-bit frame);
//    PARITY_ODD=1 -> parity 0.
//  6 Fill FIFO to FIFO_DEPTH -> s_ready=0, extra push dropped; start during busy ignored;
//    num_bytes=0 -> done pulse next cycle, busy never high, tx stays 1.

Source files
------------

// File: rtl/uart_tx_packet_engine.sv
// FIFO-buffered UART transmitter that sends packets of num_bytes frames on tx.
// Data width, parity and stop bits are parameters; the inter-frame gap is latched per packet.

module uart_tx_packet_engine #(
  parameter int         DATA_BITS  = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter int         NUM_W      = 15,
  parameter int         CNT_W      = 17,
  parameter int         GAP_W      = 2,
  parameter int         PARITY_EN  = 0,
  parameter int         PARITY_ODD = 0,
  parameter int         STOP_BITS  = 1,
  parameter logic [7:0] LF_CHAR    = 8'h0A
) (
  input  logic                        system_clock,
  input  logic                        rst_n,
  input  logic                        clock_enable,
  input  logic                        s_valid,
  input  logic [DATA_BITS-1:0]        s_data,
  output logic                        s_ready,
  input  logic                        start,
  input  logic [NUM_W-1:0]            num_bytes,
  input  logic [GAP_W-1:0]            delay,
  output logic                        tx,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            data_counter,
  output logic [7:0]                  line_counter,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CMP_W = (DATA_BITS < 8) ? DATA_BITS : 8;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             ODD       = (PARITY_ODD != 0);
  localparam logic             PAR_ON    = (PARITY_EN != 0);
  localparam logic [CMP_W-1:0] LF_CMP    = LF_CHAR[CMP_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] rd_word;

  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]     delay_q, delay_d;
  logic [NUM_W-1:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]     data_cnt_q, data_cnt_d;
  logic [7:0]           line_cnt_q, line_cnt_d;
  logic                 do_load;
  logic                 parity_bit;
  logic                 word_is_lf;

  assign s_ready    = (level_q < DEPTH_LVL);
  assign push       = s_valid && s_ready;
  assign rd_word    = mem_q[rd_ptr_q];
  assign parity_bit = (^word_q) ^ ODD;
  assign word_is_lf = (word_q[CMP_W-1:0] == LF_CMP);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  // Storage is not reset; the pointers and level define which entries are valid.
  always_ff @(posedge system_clock) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    word_d      = word_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    delay_d     = delay_q;
    remaining_d = remaining_q;
    data_cnt_d  = data_cnt_q;
    line_cnt_d  = line_cnt_q;
    do_load     = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_LOAD;
            busy_d      = 1'b1;
            remaining_d = num_bytes;
            delay_d     = delay;
          end
        end
      end
      S_LOAD: begin
        if (clock_enable) do_load = 1'b1;
      end
      S_START: begin
        if (clock_enable) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (clock_enable) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (PAR_ON) begin
              tx_d    = parity_bit;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (clock_enable) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (clock_enable) begin
          if (stop_cnt_q == LAST_STOP) begin
            data_cnt_d  = data_cnt_q + 1'b1;
            if (word_is_lf) line_cnt_d = line_cnt_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == NUM_W'(1)) begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (delay_q != '0) begin
              tx_d      = 1'b1;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              do_load = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (clock_enable) begin
          if (gap_cnt_q == delay_q - GAP_W'(1)) do_load = 1'b1;
          else gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Shared by LOAD, a back-to-back STOP and the end of GAP: the start bit goes out on this edge.
    if (do_load) begin
      if (level_q != '0) begin
        pop     = 1'b1;
        word_d  = rd_word;
        shift_d = rd_word;
        tx_d    = 1'b0;
        state_d = S_START;
      end else begin
        tx_d    = 1'b1;
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      gap_cnt_q   <= '0;
      delay_q     <= '0;
      remaining_q <= '0;
      data_cnt_q  <= '0;
      line_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      word_q      <= word_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      delay_q     <= delay_d;
      remaining_q <= remaining_d;
      data_cnt_q  <= data_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign data_counter = data_cnt_q;
  assign line_counter = line_cnt_q;
  assign fifo_level   = level_q;

endmodule
